// File: rtl/dm_job_scheduler_pkg.sv
// Shared types for the DataMover job scheduler: requester count and FSM state encoding.
package dm_job_scheduler_pkg;
  localparam int N_REQ = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_ERR,
    S_DRAIN
  } state_e;
endpackage

// File: rtl/dm_job_scheduler_rr_arbiter2.sv
// Two-way round-robin pick: the pointer breaks ties, otherwise the lone valid requester wins.
module rr_arbiter2
  import dm_job_scheduler_pkg::*;
(
  input  logic [N_REQ-1:0] i_valid,
  input  logic             i_ptr,
  output logic [N_REQ-1:0] o_grant_onehot,
  output logic             o_grant_id
);
  always_comb begin
    o_grant_id     = (&i_valid) ? i_ptr : i_valid[1];
    o_grant_onehot = '0;
    if (|i_valid) o_grant_onehot[o_grant_id] = 1'b1;
  end
endmodule

// File: rtl/dm_job_scheduler.sv
// Shares one DataMover between two requesters: round-robin accept, one-cycle launch,
// completion/error return to the owner, and a watchdog for hung jobs.
module dm_job_scheduler
  import dm_job_scheduler_pkg::*;
#(
  parameter int CNT  = 31,
  parameter int TO_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [CNT-1:0]   req_cnt_0,
  input  logic [CNT-1:0]   req_cnt_1,
  output logic [N_REQ-1:0] req_ready,
  output logic [N_REQ-1:0] req_done,
  output logic [N_REQ-1:0] req_err,
  input  logic [TO_W-1:0]  i_timeout,
  output logic             o_busy,
  output logic             o_grant_id,
  output logic             dm_run,
  output logic [CNT-1:0]   dm_num_cnt,
  input  logic             dm_idle,
  input  logic             dm_done
);
  state_e           r_state, w_next;
  logic             r_rr_ptr;
  logic             r_grant_id;
  logic [CNT-1:0]   r_num_cnt;
  logic [TO_W-1:0]  r_wd_cnt;
  logic [N_REQ-1:0] w_gnt_oh;
  logic             w_gnt_id;
  logic             w_accept;
  logic             w_wd_fire;
  logic [CNT-1:0]   w_cnt;

  rr_arbiter2 u_arb (
    .i_valid        (req_valid),
    .i_ptr          (r_rr_ptr),
    .o_grant_onehot (w_gnt_oh),
    .o_grant_id     (w_gnt_id)
  );

  assign w_accept  = (r_state == S_IDLE) && dm_idle && (|req_valid);
  assign w_cnt     = w_gnt_id ? req_cnt_1 : req_cnt_0;
  assign w_wd_fire = (i_timeout != '0) && (r_wd_cnt == i_timeout - TO_W'(1));

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    req_done  = '0;
    req_err   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          req_ready = w_gnt_oh;
          // A zero count would wrap inside the mover, so it is rejected without launch.
          w_next    = (w_cnt == '0) ? S_ERR : S_LAUNCH;
        end
      end
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        if (dm_done)        w_next = S_DONE;
        else if (w_wd_fire) w_next = S_ERR;
      end
      S_DONE: begin
        req_done[r_grant_id] = 1'b1;
        w_next               = S_IDLE;
      end
      S_ERR: begin
        req_err[r_grant_id] = 1'b1;
        w_next              = dm_idle ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: if (dm_idle) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= 1'b0;
      r_grant_id <= 1'b0;
      r_num_cnt  <= '0;
      r_wd_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_grant_id <= w_gnt_id;
        r_num_cnt  <= w_cnt;
      end
      if (r_state == S_LAUNCH)    r_wd_cnt <= '0;
      else if (r_state == S_WAIT) r_wd_cnt <= r_wd_cnt + TO_W'(1);
      if (r_state == S_DONE || r_state == S_ERR) r_rr_ptr <= ~r_grant_id;
    end
  end

  assign dm_run     = (r_state == S_LAUNCH);
  assign o_busy     = (r_state != S_IDLE);
  assign o_grant_id = r_grant_id;
  assign dm_num_cnt = r_num_cnt;
endmodule

// File: tb/tb_dm_job_scheduler.sv
// Randomized bench for dm_job_scheduler with a cycle-stepped DataMover model and a
// transaction-level prediction of grant order, outcome and timing.
module tb_dm_job_scheduler;
  localparam int CNT  = 31;
  localparam int TO_W = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [CNT-1:0]  req_cnt_0 = '0;
  logic [CNT-1:0]  req_cnt_1 = '0;
  logic [1:0]      req_ready, req_done, req_err;
  logic [TO_W-1:0] i_timeout = '0;
  logic            o_busy, o_grant_id, dm_run;
  logic [CNT-1:0]  dm_num_cnt;
  logic            dm_idle = 1'b1;
  logic            dm_done = 1'b0;

  always #5 clk = ~clk;

  dm_job_scheduler #(.CNT(CNT), .TO_W(TO_W)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
    .req_cnt_0(req_cnt_0), .req_cnt_1(req_cnt_1), .req_ready(req_ready),
    .req_done(req_done), .req_err(req_err), .i_timeout(i_timeout),
    .o_busy(o_busy), .o_grant_id(o_grant_id), .dm_run(dm_run),
    .dm_num_cnt(dm_num_cnt), .dm_idle(dm_idle), .dm_done(dm_done)
  );

  int total = 0, bad = 0, cyc = 0;
  int q0[$], q1[$], dly[$];          // pending counts per requester; mover delays (0 = never)
  int done_at = -1, idle_low = 0, last_busy = -1;
  bit dmb = 1'b0;
  int nj, nfin, stray, stab_bad, ready_bad;
  int a_cyc[32], a_id[32], a_cnt[32], r_cyc[32], r_cnt[32], f_cyc[32], f_kind[32], f_id[32];
  int m_pref = 0, e_n = 0;
  int e_id[32], e_cnt[32], e_kind[32], e_d[32];

  task automatic clear_obs();
    nj = 0; nfin = 0; stray = 0; stab_bad = 0; ready_bad = 0; last_busy = -1;
    for (int i = 0; i < 32; i++) begin r_cyc[i] = -1; f_cyc[i] = -1; end
  endtask

  // Job-level reference: tie goes to the requester not served last; outcome from count/delay/limit.
  task automatic predict(input int t);
    int a[$], b[$], d[$];
    int w, c, dd;
    a = q0; b = q1; d = dly; e_n = 0;
    while (a.size() + b.size() > 0) begin
      if (a.size() != 0 && b.size() != 0) w = m_pref;
      else w = (a.size() != 0) ? 0 : 1;
      c = (w == 1) ? b.pop_front() : a.pop_front();
      dd = 0;
      if (c != 0 && d.size() != 0) dd = d.pop_front();
      e_id[e_n] = w; e_cnt[e_n] = c; e_d[e_n] = dd;
      e_kind[e_n] = (c == 0 || (t != 0 && (dd == 0 || dd > t))) ? 2 : 1;
      e_n++;
      m_pref = 1 - w;
    end
  endtask

  // One clock: drive from model state, observe settled outputs, advance the mover model.
  task automatic cycle();
    int cur, w, d;
    req_valid = {q1.size() != 0, q0.size() != 0};
    req_cnt_0 = (q0.size() != 0) ? CNT'(q0[0]) : '0;
    req_cnt_1 = (q1.size() != 0) ? CNT'(q1[0]) : '0;
    dm_done   = (done_at == cyc);
    dm_idle   = !dmb && (idle_low == 0);
    #1;
    cur = nj - 1;
    if (o_busy) last_busy = cyc;
    if (cur >= 0 && cur < 32 && (dm_num_cnt !== CNT'(a_cnt[cur]) || o_grant_id !== 1'(a_id[cur])))
      stab_bad++;
    if ((req_ready & ~req_valid) != 0 || $countones(req_ready) > 1 || (!dm_idle && req_ready != 0))
      ready_bad++;
    if (dm_run) begin
      if (cur < 0 || cur >= 32 || r_cyc[cur] != -1) stray++;
      else begin r_cyc[cur] = cyc; r_cnt[cur] = int'(dm_num_cnt); end
      d = (dly.size() != 0) ? dly.pop_front() : 0;
      dmb = 1'b1;
      done_at = (d > 0) ? cyc + d : -1;
    end
    if (dm_done) begin dmb = 1'b0; done_at = -1; end
    if (req_done != 0 || req_err != 0) begin
      if (cur < 0 || cur >= 32 || f_cyc[cur] != -1 || $countones({req_done, req_err}) != 1) stray++;
      else begin
        f_cyc[cur]  = cyc;
        f_kind[cur] = (req_done != 0) ? 1 : 2;
        f_id[cur]   = (req_done[1] | req_err[1]) ? 1 : 0;
      end
      nfin++;
    end
    if ((req_ready & req_valid) != 0) begin
      w = req_ready[1] ? 1 : 0;
      if (nj < 32) begin
        a_cyc[nj] = cyc; a_id[nj] = w; a_cnt[nj] = (w == 1) ? q1[0] : q0[0];
      end
      nj++;
      if (w == 1) void'(q1.pop_front()); else void'(q0.pop_front());
    end
    if (idle_low > 0) idle_low--;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_jobs(input int n, input int budget);
    int k;
    k = 0;
    while ((nfin < n || dmb) && k < budget) begin cycle(); k++; end
    repeat (2) cycle();
    total++;
    if (k >= budget) begin
      bad++; $display("FAIL run_budget: finished=%0d required=%0d", nfin, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({req_ready, req_done, req_err, o_busy, o_grant_id, dm_run, dm_num_cnt} !== '0) begin
      bad++; $display("FAIL reset_outputs: got=%h want=0",
                      {req_ready, req_done, req_err, o_busy, o_grant_id, dm_run, dm_num_cnt});
    end
    reset_n = 1'b1;
    clear_obs();
    cycle();
    total++;
    if (o_busy !== 1'b0 || dm_run !== 1'b0) begin
      bad++; $display("FAIL reset_idle: got busy=%b run=%b want=0 0", o_busy, dm_run);
    end
  endtask

  task automatic test_single();
    clear_obs(); dly.delete(); i_timeout = '0;
    q0 = '{8}; dly = '{12};
    predict(0);
    run_jobs(1, 200);
    total++;
    if (a_id[0] != 0 || r_cnt[0] != 8) begin
      bad++; $display("FAIL single_grant: got id=%0d cnt=%0d want 0 8", a_id[0], r_cnt[0]);
    end
    total++;
    if (r_cyc[0] != a_cyc[0] + 1) begin
      bad++; $display("FAIL single_run_lat: got=%0d want=%0d", r_cyc[0], a_cyc[0] + 1);
    end
    total++;
    if (f_kind[0] != 1 || f_id[0] != 0 || f_cyc[0] != r_cyc[0] + 13) begin
      bad++; $display("FAIL single_done: got kind=%0d id=%0d cyc=%0d want 1 0 %0d",
                      f_kind[0], f_id[0], f_cyc[0], r_cyc[0] + 13);
    end
    total++;
    if (stray != 0 || stab_bad != 0 || ready_bad != 0) begin
      bad++; $display("FAIL single_clean: got stray=%0d stab=%0d ready=%0d want 0", stray, stab_bad, ready_bad);
    end
  endtask

  task automatic test_contention();
    clear_obs(); dly.delete(); i_timeout = '0;
    q0 = '{3, 3}; q1 = '{5, 5};
    for (int i = 0; i < 4; i++) dly.push_back($urandom_range(1, 10));
    predict(0);
    run_jobs(4, 400);
    for (int j = 0; j < 4; j++) begin
      total++;
      if (a_id[j] != e_id[j] || r_cnt[j] != e_cnt[j]) begin
        bad++; $display("FAIL cont_order[%0d]: got id=%0d cnt=%0d want %0d %0d", j, a_id[j], r_cnt[j], e_id[j], e_cnt[j]);
      end
      total++;
      if (f_kind[j] != 1 || f_id[j] != e_id[j] || f_cyc[j] != a_cyc[j] + e_d[j] + 2) begin
        bad++; $display("FAIL cont_done[%0d]: got kind=%0d cyc=%0d want 1 %0d", j, f_kind[j], f_cyc[j], a_cyc[j] + e_d[j] + 2);
      end
      if (j > 0) begin
        total++;
        if (a_cyc[j] != f_cyc[j-1] + 1) begin
          bad++; $display("FAIL cont_b2b[%0d]: got=%0d want=%0d", j, a_cyc[j], f_cyc[j-1] + 1);
        end
      end
    end
    total++;
    if (stray != 0 || stab_bad != 0) begin
      bad++; $display("FAIL cont_clean: got stray=%0d stab=%0d want 0", stray, stab_bad);
    end
  endtask

  task automatic test_zero();
    clear_obs(); dly.delete(); i_timeout = '0;
    q0 = '{4}; dly = '{3};
    predict(0); run_jobs(1, 100);
    q1 = '{0};
    predict(0); run_jobs(2, 100);
    total++;
    if (a_id[1] != 1 || f_kind[1] != 2 || f_id[1] != 1 || f_cyc[1] != a_cyc[1] + 1) begin
      bad++; $display("FAIL zero_err: got id=%0d kind=%0d fid=%0d cyc=%0d want 1 2 1 %0d",
                      a_id[1], f_kind[1], f_id[1], f_cyc[1], a_cyc[1] + 1);
    end
    total++;
    if (r_cyc[1] != -1 || stray != 0) begin
      bad++; $display("FAIL zero_norun: got run_cyc=%0d stray=%0d want -1 0", r_cyc[1], stray);
    end
    q0 = '{2}; q1 = '{2}; dly = '{2, 2};
    predict(0); run_jobs(4, 200);
    total++;
    if (a_id[2] != 0 || a_id[3] != 1) begin
      bad++; $display("FAIL zero_ptr: got order=%0d,%0d want 0,1", a_id[2], a_id[3]);
    end
  endtask

  task automatic test_timeout();
    clear_obs(); dly.delete(); i_timeout = TO_W'(20);
    q1 = '{6}; dly = '{30};
    predict(20); run_jobs(1, 200);
    total++;
    if (f_kind[0] != 2 || f_id[0] != 1 || f_cyc[0] != r_cyc[0] + 21) begin
      bad++; $display("FAIL to_err: got kind=%0d id=%0d cyc=%0d want 2 1 %0d", f_kind[0], f_id[0], f_cyc[0], r_cyc[0] + 21);
    end
    total++;
    if (last_busy != r_cyc[0] + 31) begin
      bad++; $display("FAIL to_drain: got last_busy=%0d want=%0d", last_busy, r_cyc[0] + 31);
    end
    total++;
    if (stray != 0 || nfin != 1) begin
      bad++; $display("FAIL to_swallow: got stray=%0d fin=%0d want 0 1", stray, nfin);
    end
  endtask

  task automatic test_race();
    clear_obs(); dly.delete(); i_timeout = TO_W'(20);
    q0 = '{7}; dly = '{20};
    predict(20); run_jobs(1, 200);
    total++;
    if (f_kind[0] != 1 || f_cyc[0] != r_cyc[0] + 21 || stray != 0) begin
      bad++; $display("FAIL race_done: got kind=%0d cyc=%0d stray=%0d want 1 %0d 0", f_kind[0], f_cyc[0], stray, r_cyc[0] + 21);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    clear_obs(); dly.delete(); i_timeout = '0;
    q1 = '{5}; dly = '{0};
    for (int k = 0; k < 100 && r_cyc[0] == -1; k++) cycle();
    repeat (5) cycle();
    total++;
    if (r_cyc[0] == -1 || o_busy !== 1'b1) begin
      bad++; $display("FAIL rmid_launch: got run_cyc=%0d busy=%b want launched 1", r_cyc[0], o_busy);
    end
    #3 reset_n = 1'b0;
    #1;
    total++;
    if ({req_ready, req_done, req_err, o_busy, o_grant_id, dm_run, dm_num_cnt} !== '0) begin
      bad++; $display("FAIL rmid_outputs: got=%h want=0",
                      {req_ready, req_done, req_err, o_busy, o_grant_id, dm_run, dm_num_cnt});
    end
    dmb = 1'b0; done_at = -1; m_pref = 0;
    clear_obs();
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_low = 5; q0 = '{3}; q1 = '{4}; dly = '{2, 2};
    s = cyc;
    predict(0); run_jobs(2, 200);
    total++;
    if (a_cyc[0] != s + 5 || ready_bad != 0) begin
      bad++; $display("FAIL rmid_idle_gate: got acc=%0d ready_bad=%0d want %0d 0", a_cyc[0], ready_bad, s + 5);
    end
    total++;
    if (a_id[0] != 0 || a_id[1] != 1 || f_kind[0] != 1 || f_kind[1] != 1 || stray != 0) begin
      bad++; $display("FAIL rmid_restart: got ids=%0d,%0d kinds=%0d,%0d want 0,1 1,1", a_id[0], a_id[1], f_kind[0], f_kind[1]);
    end
  endtask

  task automatic test_random();
    int n0, n1;
    for (int round = 0; round < 4; round++) begin
      clear_obs(); dly.delete(); i_timeout = TO_W'(16);
      n0 = $urandom_range(1, 4); n1 = $urandom_range(0, 4);
      for (int i = 0; i < n0; i++) q0.push_back($urandom_range(0, 5));
      for (int i = 0; i < n1; i++) q1.push_back($urandom_range(0, 5));
      for (int i = 0; i < 8; i++) dly.push_back($urandom_range(1, 24));
      predict(16);
      run_jobs(e_n, 2000);
      for (int j = 0; j < e_n; j++) begin
        total++;
        if (a_id[j] != e_id[j] || a_cnt[j] != e_cnt[j] || f_kind[j] != e_kind[j] || f_id[j] != e_id[j]) begin
          bad++; $display("FAIL rnd_job[%0d.%0d]: got id=%0d cnt=%0d kind=%0d want %0d %0d %0d",
                          round, j, a_id[j], a_cnt[j], f_kind[j], e_id[j], e_cnt[j], e_kind[j]);
        end
        total++;
        if (e_cnt[j] == 0) begin
          if (r_cyc[j] != -1 || f_cyc[j] != a_cyc[j] + 1) begin
            bad++; $display("FAIL rnd_zero[%0d.%0d]: got run=%0d fin=%0d want -1 %0d", round, j, r_cyc[j], f_cyc[j], a_cyc[j] + 1);
          end
        end else if (r_cyc[j] != a_cyc[j] + 1 || r_cnt[j] != e_cnt[j] ||
                     f_cyc[j] != a_cyc[j] + 2 + ((e_kind[j] == 1) ? e_d[j] : 16)) begin
          bad++; $display("FAIL rnd_timing[%0d.%0d]: got run=%0d fin=%0d want %0d %0d", round, j, r_cyc[j], f_cyc[j],
                          a_cyc[j] + 1, a_cyc[j] + 2 + ((e_kind[j] == 1) ? e_d[j] : 16));
        end
      end
      total++;
      if (stray != 0 || stab_bad != 0 || ready_bad != 0 || nj != e_n) begin
        bad++; $display("FAIL rnd_clean[%0d]: got stray=%0d stab=%0d ready=%0d jobs=%0d want 0 0 0 %0d",
                        round, stray, stab_bad, ready_bad, nj, e_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_zero();
    test_timeout();
    test_race();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
